// File: rtl/hpu_pkg.sv
// Shared types and width helpers for the HPU output path.
package hpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } out_sched_state_e;

    // Index width that stays at least one bit wide for single-entry cases.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int OUT_SCHED_NCORE  = 4;
    localparam int OUT_SCHED_DEPTH  = 16;
    localparam int OUT_SCHED_DW     = 32;
    localparam int OUT_SCHED_ID_W   = idx_w(OUT_SCHED_NCORE);
    localparam int OUT_SCHED_ADDR_W = idx_w(OUT_SCHED_DEPTH);

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin find-first: first set request at or after ptr, wrapping.
module rr_arb
    import hpu_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IW:0]    sum;
    logic           found;

    always_comb begin
        dbl   = {req, req} >> ptr;
        rot   = dbl[N-1:0];
        any   = |req;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        gnt   = '0;
        // Rotated vector puts ptr at bit 0; map the winning offset back to a core index.
        for (int i = 0; i < N; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                sum   = {1'b0, ptr} + (IW+1)'(i);
                if (sum >= (IW+1)'(N)) begin
                    sum = sum - (IW+1)'(N);
                end
                idx = sum[IW-1:0];
            end
        end
        for (int k = 0; k < N; k++) begin
            gnt[k] = any && (idx == IW'(k));
        end
    end

endmodule

// File: rtl/out_sched.sv
// Output scheduler: latches per-core packet requests, grants round-robin and
// streams each granted bank out as one DEPTH-word packet under backpressure.
module out_sched
    import hpu_pkg::*;
#(
    parameter  int NCORE = OUT_SCHED_NCORE,
    parameter  int DEPTH = OUT_SCHED_DEPTH,
    parameter  int DW    = OUT_SCHED_DW,
    localparam int ID_W  = idx_w(NCORE),
    localparam int AW    = idx_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCORE-1:0] core_fin,
    output logic             rd_en,
    output logic [ID_W-1:0]  rd_core,
    output logic [AW-1:0]    rd_addr,
    input  logic [DW-1:0]    rd_data,
    input  logic             dst_ready,
    output logic             dst_valid,
    output logic [DW-1:0]    dst_data,
    output logic             dst_last,
    output logic [ID_W-1:0]  dst_id,
    output logic [NCORE-1:0] pend,
    output logic             pkt_done,
    output out_sched_state_e state
);

    // Stream handshake: a word transfers on dst_valid & dst_ready; once dst_valid
    // is high, dst_data/dst_last/dst_id hold until that transfer happens.

    out_sched_state_e state_nxt;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  gnt_idx;
    logic [NCORE-1:0] gnt_oh;
    logic             gnt_any;
    logic             grant;
    logic             adv;
    logic             hs_last;
    logic             addr_en;
    logic             addr_start;
    logic             addr_last;

    rr_arb #(.N(NCORE)) u_arb (
        .req (pend),
        .ptr (rr_ptr),
        .gnt (gnt_oh),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    assign adv        = ~dst_valid | dst_ready;
    assign hs_last    = dst_valid & dst_last & dst_ready;
    assign pkt_done   = hs_last;
    assign dst_data   = rd_data;
    assign addr_en    = rd_en;
    assign addr_start = grant;
    assign addr_last  = (rd_addr == AW'(DEPTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        rd_en     = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_any) begin
                    grant     = 1'b1;
                    state_nxt = READ;
                end
            end
            READ: begin
                rd_en = adv;
                if (adv && addr_last) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (hs_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend    <= '0;
            rd_core <= '0;
            rd_addr <= '0;
            rr_ptr  <= '0;
        end else begin
            // A new request on the core being granted this cycle survives the clear.
            pend <= (pend & ~(gnt_oh & {NCORE{grant}})) | core_fin;
            if (addr_start) begin
                rd_core <= gnt_idx;
                rd_addr <= '0;
            end else if (addr_en) begin
                rd_addr <= addr_last ? '0 : rd_addr + 1'b1;
                if (addr_last) begin
                    rr_ptr <= (rd_core == ID_W'(NCORE - 1)) ? '0 : rd_core + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dst_valid <= 1'b0;
            dst_last  <= 1'b0;
            dst_id    <= '0;
        end else if (adv) begin
            dst_valid <= rd_en;
            dst_last  <= rd_en & addr_last;
            dst_id    <= rd_core;
        end
    end

endmodule

// File: tb/tb_out_sched.sv
// Directed bench for out_sched: bank model, stream monitor and per-scenario tasks.
module tb_out_sched;
    import hpu_pkg::*;

    localparam int NCORE = 4;
    localparam int DEPTH = 16;
    localparam int DW    = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [NCORE-1:0] core_fin;
    logic             rd_en;
    logic [1:0]       rd_core;
    logic [3:0]       rd_addr;
    logic [DW-1:0]    rd_data;
    logic             dst_ready;
    logic             dst_valid;
    logic [DW-1:0]    dst_data;
    logic             dst_last;
    logic [1:0]       dst_id;
    logic [NCORE-1:0] pend;
    logic             pkt_done;
    out_sched_state_e state;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [1:0]    obs_id[$];
    logic [DW-1:0] obs_data[$];
    logic          obs_last[$];
    int            obs_t[$];
    int            valid_cnt;
    int            first_valid;
    int            pkt_cnt;
    int            stall_err;
    logic          hold_chk;
    logic [DW-1:0] h_data;
    logic          h_last;
    logic [1:0]    h_id;
    logic [3:0]    ready_pat;

    out_sched #(.NCORE(NCORE), .DEPTH(DEPTH), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .core_fin  (core_fin),
        .rd_en     (rd_en),
        .rd_core   (rd_core),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .dst_ready (dst_ready),
        .dst_valid (dst_valid),
        .dst_data  (dst_data),
        .dst_last  (dst_last),
        .dst_id    (dst_id),
        .pend      (pend),
        .pkt_done  (pkt_done),
        .state     (state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Bank model: word = core id in bits 15:8, address in bits 7:0; holds when rd_en low.
    always @(posedge clk) begin
        if (rd_en) rd_data <= (DW'(rd_core) << 8) | DW'(rd_addr);
    end

    // ---------------- stream monitor ----------------
    always @(negedge clk) begin
        if (dst_valid && dst_ready) begin
            obs_id.push_back(dst_id);
            obs_data.push_back(dst_data);
            obs_last.push_back(dst_last);
            obs_t.push_back(cyc);
        end
        if (dst_valid) begin
            valid_cnt <= valid_cnt + 1;
            if (first_valid < 0) first_valid <= cyc;
        end
        if (pkt_done) pkt_cnt <= pkt_cnt + 1;
        if (hold_chk && (dst_valid !== 1'b1 || dst_data !== h_data ||
                         dst_last !== h_last || dst_id !== h_id))
            stall_err <= stall_err + 1;
        if (dst_valid && !dst_ready && rd_en) stall_err <= stall_err + 1;
        hold_chk <= dst_valid && !dst_ready;
        h_data   <= dst_data;
        h_last   <= dst_last;
        h_id     <= dst_id;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        obs_id.delete();
        obs_data.delete();
        obs_last.delete();
        obs_t.delete();
        valid_cnt   = 0;
        first_valid = -1;
        pkt_cnt     = 0;
        stall_err   = 0;
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        core_fin  = '0;
        dst_ready = 1'b1;
        ready_pat = 4'b1111;
        repeat (2) tick();
        rst = 1'b0;
        clear_obs();
    endtask

    task automatic wait_words(input int n, input int budget, output bit to);
        int k;
        k  = 0;
        to = 1'b0;
        while (obs_id.size() < n) begin
            if (k >= budget) begin
                to = 1'b1;
                break;
            end
            dst_ready = ready_pat[k % 4];
            tick();
            k++;
        end
        dst_ready = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        apply_reset();
        checks++;
        if ({dst_valid, dst_last, dst_id, rd_en, rd_core, rd_addr, pkt_done} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got v=%b l=%b id=%0d rd_en=%b core=%0d addr=%0d done=%b, want all 0",
                     dst_valid, dst_last, dst_id, rd_en, rd_core, rd_addr, pkt_done);
        end
        checks++;
        if (pend !== 4'b0000 || state !== IDLE) begin
            failures++;
            $display("FAIL reset_state: got pend=%b state=%0d, want pend=0000 state=IDLE", pend, state);
        end
    endtask

    task automatic test_single();
        bit to;
        int latch;
        apply_reset();
        core_fin = 4'b0100;
        tick();
        core_fin = '0;
        latch = cyc;
        checks++;
        if (pend !== 4'b0100) begin
            failures++;
            $display("FAIL single_pend: got %b want 0100", pend);
        end
        wait_words(16, 80, to);
        checks++;
        if (to) begin
            failures++;
            $display("FAIL single_timeout: got %0d words want 16", obs_id.size());
        end
        checks++;
        if (first_valid != latch + 2) begin
            failures++;
            $display("FAIL single_latency: first valid at cycle %0d want %0d", first_valid, latch + 2);
        end
        for (int i = 0; i < obs_id.size() && i < 16; i++) begin
            checks++;
            if (obs_id[i] !== 2'd2 || obs_data[i] !== 32'h200 + i ||
                obs_last[i] !== (i == 15) || obs_t[i] != obs_t[0] + i) begin
                failures++;
                $display("FAIL single_word%0d: got id=%0d data=%h last=%b t=%0d want id=2 data=%h last=%b t=%0d",
                         i, obs_id[i], obs_data[i], obs_last[i], obs_t[i], 32'h200 + i, (i == 15), obs_t[0] + i);
            end
        end
        repeat (4) tick();
        checks++;
        if (pkt_cnt != 1 || obs_id.size() != 16 || state !== IDLE) begin
            failures++;
            $display("FAIL single_end: got pkt_done=%0d words=%0d state=%0d want 1 16 IDLE",
                     pkt_cnt, obs_id.size(), state);
        end
    endtask

    task automatic test_backpressure();
        bit to;
        apply_reset();
        ready_pat = 4'b1001;
        core_fin  = 4'b0100;
        tick();
        core_fin = '0;
        wait_words(16, 120, to);
        ready_pat = 4'b1111;
        repeat (6) tick();
        checks++;
        if (to || obs_id.size() != 16) begin
            failures++;
            $display("FAIL bp_count: got %0d handshakes want 16", obs_id.size());
        end
        for (int i = 0; i < obs_id.size() && i < 16; i++) begin
            checks++;
            if (obs_id[i] !== 2'd2 || obs_data[i] !== 32'h200 + i || obs_last[i] !== (i == 15)) begin
                failures++;
                $display("FAIL bp_word%0d: got id=%0d data=%h last=%b want id=2 data=%h last=%b",
                         i, obs_id[i], obs_data[i], obs_last[i], 32'h200 + i, (i == 15));
            end
        end
        checks++;
        if (stall_err != 0 || pkt_cnt != 1) begin
            failures++;
            $display("FAIL bp_stall: got stall_err=%0d pkt_done=%0d want 0 1", stall_err, pkt_cnt);
        end
    endtask

    task automatic test_simultaneous();
        bit to;
        logic [1:0] exp_ids[3];
        exp_ids = '{2'd0, 2'd1, 2'd3};
        apply_reset();
        core_fin = 4'b1011;
        tick();
        core_fin = '0;
        checks++;
        if (pend !== 4'b1011) begin
            failures++;
            $display("FAIL sim_pend: got %b want 1011", pend);
        end
        wait_words(48, 200, to);
        repeat (4) tick();
        checks++;
        if (to || obs_id.size() != 48 || pkt_cnt != 3) begin
            failures++;
            $display("FAIL sim_count: got words=%0d pkt_done=%0d want 48 3", obs_id.size(), pkt_cnt);
        end
        for (int i = 0; i < obs_id.size() && i < 48; i++) begin
            checks++;
            if (obs_id[i] !== exp_ids[i / 16] || obs_data[i] !== ((DW'(exp_ids[i / 16]) << 8) | DW'(i % 16)) ||
                obs_last[i] !== ((i % 16) == 15)) begin
                failures++;
                $display("FAIL sim_word%0d: got id=%0d data=%h last=%b want id=%0d addr=%0d last=%b",
                         i, obs_id[i], obs_data[i], obs_last[i], exp_ids[i / 16], i % 16, ((i % 16) == 15));
            end
        end
    endtask

    task automatic test_fairness();
        bit to;
        logic [1:0] exp_ids[3];
        exp_ids = '{2'd0, 2'd1, 2'd0};
        apply_reset();
        core_fin = 4'b0011;
        tick();
        core_fin = '0;
        wait_words(3, 40, to);
        core_fin = 4'b0001;
        tick();
        core_fin = '0;
        checks++;
        if (to || pend !== 4'b0011) begin
            failures++;
            $display("FAIL fair_pend: got %b want 0011", pend);
        end
        wait_words(48, 200, to);
        repeat (4) tick();
        checks++;
        if (to || obs_id.size() != 48 || pkt_cnt != 3) begin
            failures++;
            $display("FAIL fair_count: got words=%0d pkt_done=%0d want 48 3", obs_id.size(), pkt_cnt);
        end
        for (int p = 0; p < 3 && p * 16 < obs_id.size(); p++) begin
            checks++;
            if (obs_id[p * 16] !== exp_ids[p]) begin
                failures++;
                $display("FAIL fair_order%0d: got id=%0d want %0d", p, obs_id[p * 16], exp_ids[p]);
            end
        end
    endtask

    task automatic test_collision();
        bit to;
        apply_reset();
        core_fin = 4'b0010;
        tick();
        tick();
        core_fin = '0;
        checks++;
        if (state !== READ || rd_core !== 2'd1 || pend !== 4'b0010) begin
            failures++;
            $display("FAIL coll_grant: got state=%0d core=%0d pend=%b want READ 1 0010", state, rd_core, pend);
        end
        wait_words(32, 150, to);
        repeat (4) tick();
        checks++;
        if (to || obs_id.size() != 32 || pkt_cnt != 2 || pend !== 4'b0000) begin
            failures++;
            $display("FAIL coll_count: got words=%0d pkt_done=%0d pend=%b want 32 2 0000",
                     obs_id.size(), pkt_cnt, pend);
        end
        for (int i = 0; i < obs_id.size() && i < 32; i++) begin
            checks++;
            if (obs_id[i] !== 2'd1 || obs_data[i] !== 32'h100 + (i % 16)) begin
                failures++;
                $display("FAIL coll_word%0d: got id=%0d data=%h want id=1 data=%h",
                         i, obs_id[i], obs_data[i], 32'h100 + (i % 16));
            end
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        apply_reset();
        core_fin = 4'b1000;
        tick();
        core_fin = '0;
        wait_words(3, 40, to);
        core_fin = 4'b0100;
        tick();
        core_fin = '0;
        wait_words(7, 40, to);
        checks++;
        if (to || pend !== 4'b0100 || obs_id[0] !== 2'd3) begin
            failures++;
            $display("FAIL mid_setup: got words=%0d pend=%b want >=7 0100", obs_id.size(), pend);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({dst_valid, dst_last, dst_id, rd_en, rd_core, rd_addr, pkt_done} !== '0 ||
            pend !== 4'b0000 || state !== IDLE) begin
            failures++;
            $display("FAIL mid_reset: got v=%b l=%b id=%0d rd_en=%b core=%0d addr=%0d pend=%b state=%0d want all 0 IDLE",
                     dst_valid, dst_last, dst_id, rd_en, rd_core, rd_addr, pend, state);
        end
        rst = 1'b0;
        clear_obs();
        repeat (40) tick();
        checks++;
        if (valid_cnt != 0 || pend !== 4'b0000) begin
            failures++;
            $display("FAIL mid_quiet: got valid cycles=%0d pend=%b want 0 0000", valid_cnt, pend);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst       = 1'b1;
        core_fin  = '0;
        dst_ready = 1'b1;
        ready_pat = 4'b1111;
        hold_chk  = 1'b0;
        clear_obs();
        test_reset();
        test_single();
        test_backpressure();
        test_simultaneous();
        test_fairness();
        test_collision();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
